// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the multi-decade BCD counter: the largest legal BCD
// digit, a 4-bit digit type and a validity helper for incoming nibbles.
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] bcd_digit_t;

    // True when the nibble is a legal BCD digit (0..9).
    function automatic logic bcd_is_valid(input bcd_digit_t nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_decade.sv
// ---------------------------------------------------------------------------
// bcd_decade
// One BCD digit register. Steps up or down when its carry/borrow input is
// set and the hold input is clear; a synchronous load overrides stepping.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, clears the digit
//   up_i       1 = increment, 0 = decrement
//   cin_i      carry-in (up) / borrow-in (down): step this digit
//   hold_i     suppress the step (saturation at the counter boundary)
//   load_i     synchronous load strobe (already validated by the parent)
//   load_val_i digit value to load
//   digit_o    registered digit
//   cout_o     carry-out (up, digit at 9) / borrow-out (down, digit at 0)
// ---------------------------------------------------------------------------
module bcd_decade
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       up_i,
    input  logic       cin_i,
    input  logic       hold_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] digit_o,
    output logic       cout_o
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;
    logic       at_limit_s;

    // Digit sits at the value that rolls over in the current direction.
    always_comb begin
        if (up_i) begin
            at_limit_s = (digit_q == BCD_MAX);
        end else begin
            at_limit_s = (digit_q == 4'd0);
        end
    end

    // Carry/borrow does not depend on hold, which keeps the chain loop-free.
    assign cout_o = cin_i & at_limit_s;

    // Next digit value: load first, then a step, else hold.
    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_val_i;
        end else if (cin_i && !hold_i) begin
            if (up_i) begin
                // ">=" also recovers any out-of-range value to 0
                if (digit_q >= BCD_MAX) begin
                    digit_d = 4'd0;
                end else begin
                    digit_d = digit_q + 4'd1;
                end
            end else begin
                if ((digit_q == 4'd0) || (digit_q > BCD_MAX)) begin
                    digit_d = BCD_MAX;
                end else begin
                    digit_d = digit_q - 4'd1;
                end
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/bcd_counter_multi.sv
// ---------------------------------------------------------------------------
// bcd_counter_multi
// Multi-decade up/down BCD counter with validated synchronous load, wrap or
// saturate boundary mode, a terminal-count pulse and a time-multiplexed digit
// scan for 7-segment drivers. Priority per cycle: rst > load > en.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         count enable, one step per cycle (ignored while load=1)
//   up         1 = increment, 0 = decrement
//   sat        1 = saturate at the boundary, 0 = wrap
//   load       synchronous load strobe
//   load_val   BCD value to load, digit 0 in the LSB nibble
//   count      registered BCD count
//   tc         registered terminal-count pulse
//   load_err   last load was rejected (contained a non-BCD nibble)
//   scan_sel   one-hot digit select
//   scan_digit BCD nibble of the selected digit
// ---------------------------------------------------------------------------
module bcd_counter_multi
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up,
    input  logic                    sat,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tc,
    output logic                    load_err,
    output logic [NUM_DIGITS-1:0]   scan_sel,
    output logic [3:0]              scan_digit
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic             step_req_s;
    logic             boundary_s;
    logic             hold_s;
    logic             load_ok_s;
    logic             dec_load_s;
    bcd_digit_t       digit_s [NUM_DIGITS];

    logic             tc_q;
    logic             tc_d;
    logic             load_err_q;
    logic             load_err_d;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // A step is requested only when enabled and no load is pending.
    assign step_req_s = en & ~load;

    // Load is accepted only if every nibble is a legal BCD digit.
    always_comb begin
        load_ok_s = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_ok_s = load_ok_s & bcd_is_valid(load_val[4*i +: 4]);
        end
    end

    assign dec_load_s = load & load_ok_s;

    // The top digit's carry/borrow-out is set exactly when a requested step
    // would cross the boundary (all 9s up, all 0s down). Wrapping falls out
    // of the ripple naturally; saturation simply holds every digit.
    assign hold_s = sat & boundary_s;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
        logic cin_s;
        logic cout_s;

        if (gi == 0) begin : g_first
            assign cin_s = step_req_s;
        end else begin : g_chain
            assign cin_s = g_dec[gi-1].cout_s;
        end

        bcd_decade u_decade (
            .clk        (clk),
            .rst        (rst),
            .up_i       (up),
            .cin_i      (cin_s),
            .hold_i     (hold_s),
            .load_i     (dec_load_s),
            .load_val_i (load_val[4*gi +: 4]),
            .digit_o    (digit_s[gi]),
            .cout_o     (cout_s)
        );

        assign count[4*gi +: 4] = digit_s[gi];
    end

    assign boundary_s = g_dec[NUM_DIGITS-1].cout_s;

    // Terminal count follows a boundary step; load_err tracks the last load.
    always_comb begin
        tc_d = boundary_s;
        if (load) begin
            load_err_d = ~load_ok_s;
        end else begin
            load_err_d = load_err_q;
        end
    end

    // Status flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign tc       = tc_q;
    assign load_err = load_err_q;

    // Scan prescaler and digit index advance, independent of en/load.
    always_comb begin
        if (pre_q == PRE_MAX) begin
            pre_d = {PRE_W{1'b0}};
            if (idx_q == IDX_MAX) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            pre_d = pre_q + PRE_W'(1);
            idx_d = idx_q;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= {PRE_W{1'b0}};
            idx_q <= {IDX_W{1'b0}};
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

    // One-hot select and digit mux, decoded from registered index and count.
    always_comb begin
        scan_sel   = {NUM_DIGITS{1'b0}};
        scan_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                scan_sel[i] = 1'b1;
                scan_digit  = digit_s[i];
            end else begin
                scan_sel[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter_multi.sv
module tb_bcd_counter_multi;

    localparam int ND = 4;
    localparam int SD = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic          up;
    logic          sat;
    logic          load;
    logic [15:0]   load_val;
    logic [15:0]   count;
    logic          tc;
    logic          load_err;
    logic [3:0]    scan_sel;
    logic [3:0]    scan_digit;

    int total = 0;
    int bad   = 0;

    bcd_counter_multi #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .up         (up),
        .sat        (sat),
        .load       (load),
        .load_val   (load_val),
        .count      (count),
        .tc         (tc),
        .load_err   (load_err),
        .scan_sel   (scan_sel),
        .scan_digit (scan_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] scan_val;
        int          idx;

        rst = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; load_val = 16'h0000;
        #2;

        // 1. reset overrides en and load
        rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 16'h1234;
        tick();
        check("rst_count", {16'h0, count}, 32'h0000);
        check("rst_tc", {31'h0, tc}, 32'h0);
        check("rst_lerr", {31'h0, load_err}, 32'h0);
        check("rst_sel", {28'h0, scan_sel}, 32'h1);
        rst = 1'b0; en = 1'b0; load = 1'b0;
        tick();
        check("post_rst_count", {16'h0, count}, 32'h0000);
        check("post_rst_tc", {31'h0, tc}, 32'h0);
        check("post_rst_lerr", {31'h0, load_err}, 32'h0);
        check("post_rst_sel", {28'h0, scan_sel}, 32'h1);

        // 2. carry ripple and wrap
        load = 1'b1; load_val = 16'h0099;
        tick();
        check("ld_0099", {16'h0, count}, 32'h0099);
        load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
        tick();
        check("ripple_0100", {16'h0, count}, 32'h0100);
        check("ripple_tc", {31'h0, tc}, 32'h0);
        en = 1'b0; load = 1'b1; load_val = 16'h9998;
        tick();
        check("ld_9998", {16'h0, count}, 32'h9998);
        load = 1'b0; en = 1'b1;
        tick();
        check("up_9999", {16'h0, count}, 32'h9999);
        check("up_9999_tc", {31'h0, tc}, 32'h0);
        tick();
        check("wrap_up", {16'h0, count}, 32'h0000);
        check("wrap_up_tc", {31'h0, tc}, 32'h1);
        en = 1'b0;
        tick();
        check("idle_tc", {31'h0, tc}, 32'h0);

        // down wrap from all-0s, then up saturate at all-9s
        en = 1'b1; up = 1'b0; sat = 1'b0;
        tick();
        check("wrap_dn", {16'h0, count}, 32'h9999);
        check("wrap_dn_tc", {31'h0, tc}, 32'h1);
        up = 1'b1; sat = 1'b1;
        tick();
        check("sat_up", {16'h0, count}, 32'h9999);
        check("sat_up_tc", {31'h0, tc}, 32'h1);
        en = 1'b0;

        // 3. saturate down
        load = 1'b1; load_val = 16'h0001;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0; sat = 1'b1;
        tick();
        check("satdn1", {16'h0, count}, 32'h0000);
        check("satdn1_tc", {31'h0, tc}, 32'h0);
        tick();
        check("satdn2", {16'h0, count}, 32'h0000);
        check("satdn2_tc", {31'h0, tc}, 32'h1);
        tick();
        check("satdn3", {16'h0, count}, 32'h0000);
        check("satdn3_tc", {31'h0, tc}, 32'h1);
        en = 1'b0;
        tick();
        check("satdn_off_tc", {31'h0, tc}, 32'h0);

        // borrow ripple
        sat = 1'b0; load = 1'b1; load_val = 16'h1000;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        check("borrow_0999", {16'h0, count}, 32'h0999);
        check("borrow_tc", {31'h0, tc}, 32'h0);
        en = 1'b0;

        // 4. invalid load
        load = 1'b1; load_val = 16'h12A4;
        tick();
        check("bad_ld_count", {16'h0, count}, 32'h0999);
        check("bad_ld_err", {31'h0, load_err}, 32'h1);
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        check("step_after_bad", {16'h0, count}, 32'h1000);
        check("err_sticky", {31'h0, load_err}, 32'h1);
        en = 1'b0; load = 1'b1; load_val = 16'h0042;
        tick();
        check("good_ld", {16'h0, count}, 32'h0042);
        check("good_ld_err", {31'h0, load_err}, 32'h0);
        load_val = 16'hF000;
        tick();
        check("bad_top_count", {16'h0, count}, 32'h0042);
        check("bad_top_err", {31'h0, load_err}, 32'h1);

        // 5. priority: load over en, load never pulses tc, rst over load
        en = 1'b1; up = 1'b1; load_val = 16'h0500;
        tick();
        check("prio_count", {16'h0, count}, 32'h0500);
        check("prio_tc", {31'h0, tc}, 32'h0);
        check("prio_err", {31'h0, load_err}, 32'h0);
        load_val = 16'h9999;
        tick();
        tick();
        check("ld9999_count", {16'h0, count}, 32'h9999);
        check("ld9999_tc", {31'h0, tc}, 32'h0);
        load_val = 16'hAAAA;
        tick();
        check("pre_rst_err", {31'h0, load_err}, 32'h1);
        rst = 1'b1;
        tick();
        check("rst_ld_count", {16'h0, count}, 32'h0000);
        check("rst_ld_err", {31'h0, load_err}, 32'h0);
        check("rst_ld_sel", {28'h0, scan_sel}, 32'h1);

        // 6. scan sequence with static count 1234
        rst = 1'b0; en = 1'b0; load = 1'b1; load_val = 16'h1234;
        tick();
        load = 1'b0;
        scan_val = 16'h1234;
        for (int t = 1; t <= 20; t++) begin
            idx = (t / SD) % ND;
            check("scan_sel", {28'h0, scan_sel}, 32'h1 << idx);
            check("scan_digit", {28'h0, scan_digit}, {28'h0, scan_val[idx*4 +: 4]});
            tick();
        end
        check("scan_count", {16'h0, count}, 32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
